adder_result_stage: RTL and testbench
=====================================

ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Purpose: downstream stage of the 8-bit carry-lookahead add/sub unit; captures sum and carries, derives flags, buffers results in a 2-entry queue and holds a running accumulator fed back to the adder A operand.

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
- clk: input, 1 bit; rising-edge clock.
- rst_n: input, 1 bit; async active-low reset.
- in_valid: input, 1 bit; adder result presented.
- in_ready: output, 1 bit; stage can accept.
- S: input, 8 bits; adder sum.
- c7: input, 1 bit; adder carry out of bit 7.
- c6: input, 1 bit; adder carry out of bit 6.
- m: input, 1 bit; mode used by adder (0 add, 1 subtract).
- acc_en: input, 1 bit; load accepted S into accumulator.
- acc_clr: input, 1 bit; synchronous accumulator clear.
- out_valid: output, 1 bit; queue head valid.
- out_ready: input, 1 bit; consumer accepts head.
- R: output, 8 bits; head result.
- C: output, 1 bit; head carry/borrow flag.
- V: output, 1 bit; head overflow flag.
- N: output, 1 bit; head negative flag.
- Z: output, 1 bit; head zero flag.
- acc: output, 8 bits; accumulator, drives adder A.
- count: output, 2 bits; queue occupancy 0..2.
REQ-003 No parameters; all widths fixed.

Function
REQ-004 A push SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-005 in_ready SHALL equal (count != 2), combinationally from registered count only; no dependence on out_ready.
REQ-006 Flags SHALL be computed from the pushed inputs and stored with S: C = c7 XOR m; V = c7 XOR c6; N = S[7]; Z = (S == 0x00).
REQ-007 Queue SHALL be FIFO, depth 2, with registered outputs only; latency from push to out_valid=1 SHALL be exactly 1 cycle; no combinational in-to-out bypass.
REQ-008 out_valid SHALL equal (count != 0); R/C/V/N/Z SHALL show the oldest entry and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 Occupancy control SHALL be a 3-state FSM, EMPTY (count 0), ONE (count 1), FULL (count 2):
- EMPTY: push goes to ONE.
- ONE: push only goes to FULL; pop only goes to EMPTY; push and pop together stay in ONE with the new entry at head next cycle.
- FULL: pop goes to ONE; push is impossible (in_ready=0).
REQ-010 In EMPTY, out_ready SHALL be ignored; no pop occurs and count SHALL NOT underflow.
REQ-011 In FULL, in_valid SHALL be ignored; the presented data SHALL NOT be written and count SHALL NOT exceed 2.
REQ-012 Read/write pointers SHALL be 1 bit and wrap modulo 2.
REQ-013 Accumulator update on each clk edge, by priority:
- acc_clr=1: acc is set to 0x00.
- else a push with acc_en=1: acc is set to S.
- else acc holds.
REQ-014 acc_en without a push SHALL leave acc unchanged.
REQ-015 acc SHALL update on push independently of queue pops.

Reset
REQ-016 While rst_n=0, asynchronously and without waiting for clk, outputs SHALL be: count=0 (EMPTY), in_ready=1, out_valid=0, R=0x00, C=V=N=Z=0, acc=0x00.
REQ-017 Reset mid-operation SHALL discard all queued entries.
REQ-018 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Overflow: S=0x80, c7=0, c6=1, m=0, push, out_ready=1 -> next cycle out_valid=1, R=0x80, C=0, V=1, N=1, Z=0.
- Subtract equal: S=0x00, c7=1, c6=1, m=1, acc_en=1 -> R=0x00, C=0, V=0, N=0, Z=1, acc=0x00.
- Fill: out_ready=0, three consecutive in_valid with S=0x11, 0x22, 0x33 -> count=2, in_ready=0, 0x33 dropped; then out_ready=1 -> R=0x11 then 0x22, then out_valid=0.
- Simultaneous push and pop at count=1 (head 0x11, push 0x44) -> count stays 1, next R=0x44.
- Reset mid-operation: count=2, acc=0x5A, rst_n low between edges -> immediately out_valid=0, in_ready=1, acc=0x00, count=0.
- Accumulator priority: acc_clr=1 and acc_en=1 with push of S=0x7E -> acc=0x00, entry 0x7E still queued.

Source files
------------

// File: rtl/adder_result_stage.sv
// adder_result_stage
//   Result stage behind the 8-bit carry-lookahead add/sub unit.
//   - Captures the adder sum and carries when a result is pushed.
//   - Derives the carry/borrow, overflow, negative and zero flags at push time
//     and stores them alongside the sum.
//   - Buffers results in a 2-entry FIFO whose head is presented on R/C/V/N/Z.
//   - Holds a running accumulator that is fed back to the adder A operand.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   adder result presented
//   in_ready   out  stage can accept (queue not full)
//   S          in   [7:0] adder sum
//   c7         in   adder carry out of bit 7
//   c6         in   adder carry out of bit 6
//   m          in   adder mode (0 add, 1 subtract)
//   acc_en     in   load the pushed S into the accumulator
//   acc_clr    in   synchronous accumulator clear (wins over acc_en)
//   out_valid  out  queue head valid
//   out_ready  in   consumer accepts the head
//   R          out  [7:0] head result
//   C          out  head carry/borrow flag
//   V          out  head overflow flag
//   N          out  head negative flag
//   Z          out  head zero flag
//   acc        out  [7:0] accumulator, drives adder A
//   count      out  [1:0] queue occupancy 0..2

module adder_result_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] S,
  input  logic       c7,
  input  logic       c6,
  input  logic       m,
  input  logic       acc_en,
  input  logic       acc_clr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] R,
  output logic       C,
  output logic       V,
  output logic       N,
  output logic       Z,
  output logic [7:0] acc,
  output logic [1:0] count
);

  // Occupancy state; the encoding doubles as the count output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t state, state_next;

  // Queue storage: sum plus the four flags, one slot per pointer value.
  logic [7:0] res_mem  [2];
  logic       c_mem    [2];
  logic       v_mem    [2];
  logic       n_mem    [2];
  logic       z_mem    [2];

  logic       wr_ptr;
  logic       rd_ptr;

  logic       push;
  logic       pop;

  // Flags derived from the presented adder result.
  logic       c_in;
  logic       v_in;
  logic       n_in;
  logic       z_in;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // in_ready depends on registered state only, never on out_ready, so a full
  // queue refuses data even in a cycle where the head is being popped.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign count     = state;

  assign push = in_valid  && in_ready;
  assign pop  = out_ready && out_valid;

  // ---------------------------------------------------------------------------
  // Flag derivation
  // ---------------------------------------------------------------------------
  // In subtract mode the adder computes A + ~B + 1, so a carry out means
  // "no borrow"; XOR with m turns it into a borrow flag.
  assign c_in = c7 ^ m;
  assign v_in = c7 ^ c6;
  assign n_in = S[7];
  assign z_in = (S == 8'h00);

  // ---------------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        // out_ready is irrelevant here: pop is gated by out_valid.
        if (push) begin
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_next = FULL;
        end else if (pop && !push) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low, so only a pop can change occupancy.
        if (pop) begin
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers (1 bit each, wrap modulo 2)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Push and pop together in ONE writes the slot after the head; the read
  // pointer advances onto it, so the new entry becomes head next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        res_mem[i] <= '0;
        c_mem[i]   <= 1'b0;
        v_mem[i]   <= 1'b0;
        n_mem[i]   <= 1'b0;
        z_mem[i]   <= 1'b0;
      end
    end else if (push) begin
      res_mem[wr_ptr] <= S;
      c_mem[wr_ptr]   <= c_in;
      v_mem[wr_ptr]   <= v_in;
      n_mem[wr_ptr]   <= n_in;
      z_mem[wr_ptr]   <= z_in;
    end
  end

  // Head outputs come straight from storage registers; there is no path from
  // the input data to R/C/V/N/Z within a cycle.
  assign R = res_mem[rd_ptr];
  assign C = c_mem[rd_ptr];
  assign V = v_mem[rd_ptr];
  assign N = n_mem[rd_ptr];
  assign Z = z_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  // Loads only on an accepted push, so acc_en on a refused or absent push
  // leaves the value alone. Pops have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (push && acc_en) begin
      acc <= S;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Testbench for adder_result_stage: directed vectors, a queue-based reference
// model checked on every falling edge, and hand-computed literal checks.

module tb_adder_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] S;
  logic       c7;
  logic       c6;
  logic       m;
  logic       acc_en;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] R;
  logic       C;
  logic       V;
  logic       N;
  logic       Z;
  logic [7:0] acc;
  logic [1:0] count;

  int n_chk  = 0;
  int n_fail = 0;

  adder_result_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .c7        (c7),
    .c6        (c6),
    .m         (m),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .C         (C),
    .V         (V),
    .N         (N),
    .Z         (Z),
    .acc       (acc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of {R,C,V,N,Z} words and an accumulator value.
  // ---------------------------------------------------------------------------
  logic [11:0] mq[$];
  logic [7:0]  macc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      macc = 8'h00;
    end else begin
      bit do_push, do_pop;
      logic [11:0] e;
      do_push = in_valid && (mq.size() < 2);
      do_pop  = out_ready && (mq.size() > 0);
      e = {S, c7 ^ m, c7 ^ c6, S[7], (S == 8'h00)};
      if (acc_clr)              macc = 8'h00;
      else if (do_push && acc_en) macc = S;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    chk("m_count",     32'(count),     32'(mq.size()));
    chk("m_in_ready",  32'(in_ready),  32'(mq.size() != 2));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_acc",       32'(acc),       32'(macc));
    if (mq.size() != 0)
      chk("m_head", 32'({R, C, V, N, Z}), 32'(mq[0]));
  end

  // Drive one cycle of inputs, then return #1 after the rising edge.
  task automatic drive(input logic v, input logic [7:0] s, input logic k7,
                       input logic k6, input logic mm, input logic en,
                       input logic clr, input logic ordy);
    in_valid = v; S = s; c7 = k7; c6 = k6; m = mm;
    acc_en = en; acc_clr = clr; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; S = '0; c7 = 1'b0; c6 = 1'b0; m = 1'b0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_R",         32'(R),         32'h00);
    chk("rst_flags",     32'({C, V, N, Z}), 32'h0);
    chk("rst_acc",       32'(acc),       32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Overflow: 0x80 with c7=0, c6=1 in add mode; also loads acc.
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovf_valid", 32'(out_valid), 32'd1);
    chk("ovf_R",     32'(R),         32'h80);
    chk("ovf_CVNZ",  32'({C, V, N, Z}), 32'b0110);
    chk("ovf_acc",   32'(acc),       32'h80);
    idle(1'b1);
    chk("ovf_drain", 32'(count), 32'd0);

    // Subtract equal: result zero, carry set means no borrow.
    drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sub_R",    32'(R),            32'h00);
    chk("sub_CVNZ", 32'({C, V, N, Z}), 32'b0001);
    chk("sub_acc",  32'(acc),          32'h00);
    idle(1'b1);

    // acc_en without a push leaves acc alone.
    drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    drive(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("en_nopush_acc", 32'(acc), 32'h3C);

    // Fill: third push refused, even with acc_en.
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill1_count", 32'(count), 32'd1);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill2_count", 32'(count), 32'd2);
    chk("fill2_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fill3_count", 32'(count), 32'd2);
    chk("fill3_R",     32'(R),     32'h11);
    chk("fill3_acc",   32'(acc),   32'h3C);
    idle(1'b1);
    chk("drain1_R",     32'(R),     32'h22);
    chk("drain1_count", 32'(count), 32'd1);
    idle(1'b1);
    chk("drain2_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 1.
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_R",     32'(R),     32'h44);

    // Reset mid-operation with two entries and acc=0x5A.
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_acc",   32'(acc),   32'h5A);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_acc",   32'(acc),       32'h00);
    chk("mid_rst_count", 32'(count),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // First push right after reset release.
    drive(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_R",     32'(R),     32'h21);
    chk("post_rst_acc",   32'(acc),   32'h21);

    // acc_clr beats acc_en; the pushed entry is still queued.
    drive(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("prio_acc",   32'(acc),   32'h00);
    chk("prio_R",     32'(R),     32'h7E);
    chk("prio_count", 32'(count), 32'd1);
    idle(1'b1);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
